// File: rtl/loop_filter_pkg.sv
// loop_filter_pkg: shared types and helpers for the ADPLL PI loop filter.
//   - lock_state_e : gear-shift FSM states (ACQUIRE, TRACK)
//   - calc_t       : wide signed scratch type for fixed-point arithmetic
//   - sat_signed   : clamp a value to the range of a w-bit signed number
//   - round_half_up: add half an LSB, then drop 'frac' fractional bits
//   - DEF_*        : default acquisition / tracking gain codes
package loop_filter_pkg;

    typedef enum logic {
        ACQUIRE = 1'b0,
        TRACK   = 1'b1
    } lock_state_e;

    // Wide enough for every intermediate at any sane parameterisation.
    // Synthesis trims the unused sign-extension bits.
    typedef logic signed [63:0] calc_t;

    // Kp has 2 fractional bits, Ki has 5.
    localparam logic [3:0] DEF_KP_ACQ = 4'b0100;    // 1.0
    localparam logic [5:0] DEF_KI_ACQ = 6'b001000;  // 0.25
    localparam logic [3:0] DEF_KP_TRK = 4'b0010;    // 0.5
    localparam logic [5:0] DEF_KI_TRK = 6'b000010;  // 0.0625

    function automatic calc_t sat_signed(input calc_t v, input int unsigned w);
        calc_t hi;
        calc_t lo;
        hi = (calc_t'(1) <<< (w - 1)) - calc_t'(1);
        lo = -hi - calc_t'(1);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic calc_t round_half_up(input calc_t v, input int unsigned frac);
        if (frac == 0) return v;
        return (v + (calc_t'(1) <<< (frac - 1))) >>> frac;
    endfunction

endpackage

// File: rtl/lock_detector.sv
// lock_detector: gear-shift lock FSM for the PI loop filter.
// Evaluates |error| of each valid sample against the lock/unlock thresholds
// and counts consecutive qualifying samples to move between ACQUIRE and TRACK.
// Ports:
//   gen_clk_i       loop clock
//   reset_i         asynchronous, active-high reset
//   sample_valid_i  error_i carries a sample to evaluate this cycle
//   error_i         signed phase error sample
//   locked_o        FSM is in TRACK
// Only built when LOOP_FILTER_GEAR_SHIFT_EN is defined; otherwise the file is
// empty so no orphan module appears in the default build.
`ifdef LOOP_FILTER_GEAR_SHIFT_EN
module lock_detector
    import loop_filter_pkg::*;
#(
    parameter int ERROR_WIDTH   = 8,
    parameter int LOCK_THRESH   = 2,
    parameter int LOCK_COUNT    = 16,
    parameter int UNLOCK_THRESH = 8,
    parameter int UNLOCK_COUNT  = 4
) (
    input  logic                          gen_clk_i,
    input  logic                          reset_i,
    input  logic                          sample_valid_i,
    input  logic signed [ERROR_WIDTH-1:0] error_i,
    output logic                          locked_o
);

    localparam int CNT_MAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [ERROR_WIDTH-1:0] LOCK_TH   = ERROR_WIDTH'(LOCK_THRESH);
    localparam logic [ERROR_WIDTH-1:0] UNLOCK_TH = ERROR_WIDTH'(UNLOCK_THRESH);
    localparam logic [CNT_W-1:0]       LOCK_N    = CNT_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0]       UNLOCK_N  = CNT_W'(UNLOCK_COUNT);

    lock_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [ERROR_WIDTH-1:0] mag;

    // |e|, with the most-negative code mapped to the largest positive one.
    always_comb begin
        if (error_i == {1'b1, {(ERROR_WIDTH-1){1'b0}}})
            mag = {1'b0, {(ERROR_WIDTH-1){1'b1}}};
        else if (error_i[ERROR_WIDTH-1])
            mag = -error_i;
        else
            mag = error_i;
    end

    always_ff @(posedge gen_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ACQUIRE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cnt_inc = cnt_q + 1'b1;
        if (sample_valid_i) begin
            case (state_q)
                ACQUIRE: begin
                    if (mag <= LOCK_TH) begin
                        if (cnt_inc == LOCK_N) begin
                            state_d = TRACK;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                TRACK: begin
                    if (mag > UNLOCK_TH) begin
                        if (cnt_inc == UNLOCK_N) begin
                            state_d = ACQUIRE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: begin
                    state_d = ACQUIRE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign locked_o = (state_q == TRACK);

endmodule
`endif

// File: rtl/pi_loop_filter.sv
// pi_loop_filter: ADPLL digital loop filter. Turns signed phase-error samples
// into a signed DCO control code through proportional + integral paths with
// a saturating, anti-windup integrator, output rounding and clipping.
// Build option: define LOOP_FILTER_GEAR_SHIFT_EN to enable the lock FSM and
// tracking gains; without it acquisition gains are always used and locked_o=0.
// Ports:
//   gen_clk_i, reset_i        loop clock, asynchronous active-high reset
//   error_valid_i, error_i    new signed phase-error sample
//   kp_acq_i, ki_acq_i        acquisition gains (unsigned fixed point)
//   kp_trk_i, ki_trk_i        tracking gains (unsigned fixed point)
//   freeze_i                  hold the integrator, P path stays active
//   dco_cc_o, dco_cc_valid_o  control code and its one-cycle update strobe
//   locked_o                  lock FSM is in TRACK
//   sat_o                     last output was clipped
// Pipeline: edge 0 captures sample+gains+freeze, edge 1 updates state/outputs.
module pi_loop_filter
    import loop_filter_pkg::*;
#(
    parameter int ERROR_WIDTH   = 8,
    parameter int DCO_CC_WIDTH  = 9,
    parameter int KP_WIDTH      = 4,
    parameter int KP_FRAC_WIDTH = 2,
    parameter int KI_WIDTH      = 6,
    parameter int KI_FRAC_WIDTH = 5,   // must be >= KP_FRAC_WIDTH
    parameter int ACC_WIDTH     = 16,
    parameter int LOCK_THRESH   = 2,
    parameter int LOCK_COUNT    = 16,
    parameter int UNLOCK_THRESH = 8,
    parameter int UNLOCK_COUNT  = 4
) (
    input  logic                           gen_clk_i,
    input  logic                           reset_i,
    input  logic                           error_valid_i,
    input  logic signed [ERROR_WIDTH-1:0]  error_i,
    input  logic        [KP_WIDTH-1:0]     kp_acq_i,
    input  logic        [KI_WIDTH-1:0]     ki_acq_i,
    input  logic        [KP_WIDTH-1:0]     kp_trk_i,
    input  logic        [KI_WIDTH-1:0]     ki_trk_i,
    input  logic                           freeze_i,
    output logic signed [DCO_CC_WIDTH-1:0] dco_cc_o,
    output logic                           dco_cc_valid_o,
    output logic                           locked_o,
    output logic                           sat_o
);

    localparam int STAGES  = 1;
    localparam int P_W     = ERROR_WIDTH + KP_WIDTH + 1;
    localparam int KIE_W   = ERROR_WIDTH + KI_WIDTH + 1;
    localparam int FRAC_SH = KI_FRAC_WIDTH - KP_FRAC_WIDTH;

    logic [STAGES:0]                vld_pipe_q;
    logic signed [ERROR_WIDTH-1:0]  err_q;
    logic [KP_WIDTH-1:0]            kp_q, kp_sel;
    logic [KI_WIDTH-1:0]            ki_q, ki_sel;
    logic                           frz_q;
    logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic signed [DCO_CC_WIDTH-1:0] dco_q, dco_d;
    logic                           sat_q, sat_d;
    logic                           locked;

`ifdef LOOP_FILTER_GEAR_SHIFT_EN
    // The detector sees the captured sample, so lock changes on edge 1 and
    // the new gear applies to samples captured after that edge.
    lock_detector #(
        .ERROR_WIDTH   (ERROR_WIDTH),
        .LOCK_THRESH   (LOCK_THRESH),
        .LOCK_COUNT    (LOCK_COUNT),
        .UNLOCK_THRESH (UNLOCK_THRESH),
        .UNLOCK_COUNT  (UNLOCK_COUNT)
    ) u_lock (
        .gen_clk_i      (gen_clk_i),
        .reset_i        (reset_i),
        .sample_valid_i (vld_pipe_q[0]),
        .error_i        (err_q),
        .locked_o       (locked)
    );
    assign kp_sel = locked ? kp_trk_i : kp_acq_i;
    assign ki_sel = locked ? ki_trk_i : ki_acq_i;
`else
    logic unused_trk;
    assign unused_trk = ^{kp_trk_i, ki_trk_i};
    assign locked     = 1'b0;
    assign kp_sel     = kp_acq_i;
    assign ki_sel     = ki_acq_i;
`endif

    always_ff @(posedge gen_clk_i or posedge reset_i) begin
        if (reset_i) begin
            vld_pipe_q <= '0;
            err_q      <= '0;
            kp_q       <= '0;
            ki_q       <= '0;
            frz_q      <= 1'b0;
            acc_q      <= '0;
            dco_q      <= '0;
            sat_q      <= 1'b0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[STAGES-1:0], error_valid_i};
            if (error_valid_i) begin
                err_q <= error_i;
                kp_q  <= kp_sel;
                ki_q  <= ki_sel;
                frz_q <= freeze_i;
            end
            if (vld_pipe_q[0]) begin
                acc_q <= acc_d;
                dco_q <= dco_d;
                sat_q <= sat_d;
            end
        end
    end

    logic signed [P_W-1:0]   p_prod;
    logic signed [KIE_W-1:0] kie_prod;
    calc_t kie, cand, sum, rnd, clip;

    always_comb begin
        // Gains are unsigned: a zero MSB makes them positive signed operands.
        p_prod   = err_q * $signed({1'b0, kp_q});
        kie_prod = err_q * $signed({1'b0, ki_q});
        // A frozen integrator contributes its held value only, so the output
        // is the P path plus the current integrator.
        kie  = frz_q ? calc_t'(0) : calc_t'(kie_prod);
        cand = sat_signed(calc_t'(acc_q) + kie, ACC_WIDTH);
        sum  = (calc_t'(p_prod) <<< FRAC_SH) + cand;
        rnd  = round_half_up(sum, KI_FRAC_WIDTH);
        clip = sat_signed(rnd, DCO_CC_WIDTH);

        sat_d = (clip != rnd);
        dco_d = DCO_CC_WIDTH'(clip);
        acc_d = ACC_WIDTH'(cand);
        // Anti-windup: stop integrating further into a clipped rail.
        if ((rnd > clip && kie > calc_t'(0)) || (rnd < clip && kie < calc_t'(0)))
            acc_d = acc_q;
    end

    assign dco_cc_o       = dco_q;
    assign dco_cc_valid_o = vld_pipe_q[STAGES];
    assign locked_o       = locked;
    assign sat_o          = sat_q;

endmodule

// File: tb/tb_pi_loop_filter.sv
module tb_pi_loop_filter;

`ifdef LOOP_FILTER_GEAR_SHIFT_EN
    localparam bit GEAR = 1'b1;
`else
    localparam bit GEAR = 1'b0;
`endif

    logic              gen_clk_i = 1'b0;
    logic              reset_i;
    logic              error_valid_i;
    logic signed [7:0] error_i;
    logic [3:0]        kp_acq_i, kp_trk_i;
    logic [5:0]        ki_acq_i, ki_trk_i;
    logic              freeze_i;
    logic signed [8:0] dco_cc_o;
    logic              dco_cc_valid_o, locked_o, sat_o;

    int errors = 0;
    int checks = 0;

    always #5 gen_clk_i = ~gen_clk_i;

    pi_loop_filter dut (
        .gen_clk_i      (gen_clk_i),
        .reset_i        (reset_i),
        .error_valid_i  (error_valid_i),
        .error_i        (error_i),
        .kp_acq_i       (kp_acq_i),
        .ki_acq_i       (ki_acq_i),
        .kp_trk_i       (kp_trk_i),
        .ki_trk_i       (ki_trk_i),
        .freeze_i       (freeze_i),
        .dco_cc_o       (dco_cc_o),
        .dco_cc_valid_o (dco_cc_valid_o),
        .locked_o       (locked_o),
        .sat_o          (sat_o)
    );

    // Drive one cycle of stimulus at the falling edge; callers check outputs
    // right after, while the registered outputs are stable.
    task automatic step(input logic v, input logic signed [7:0] e, input logic f);
        @(negedge gen_clk_i);
        error_valid_i = v;
        error_i       = e;
        freeze_i      = f;
    endtask

    task automatic do_reset;
        @(negedge gen_clk_i);
        reset_i = 1'b1; error_valid_i = 1'b0; error_i = '0; freeze_i = 1'b0;
        repeat (2) @(negedge gen_clk_i);
        reset_i = 1'b0;
    endtask

    task automatic test_reset;
        reset_i = 1'b1; error_valid_i = 1'b0; error_i = '0; freeze_i = 1'b0;
        repeat (2) @(negedge gen_clk_i);
        checks++; if (dco_cc_o !== 9'sd0) begin errors++; $display("FAIL reset_cc: got %0d expected 0", dco_cc_o); end
        checks++; if (dco_cc_valid_o !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", dco_cc_valid_o); end
        checks++; if (sat_o !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b expected 0", sat_o); end
        checks++; if (locked_o !== 1'b0) begin errors++; $display("FAIL reset_lock: got %b expected 0", locked_o); end
        reset_i = 1'b0;
        @(negedge gen_clk_i);
        checks++; if (dco_cc_valid_o !== 1'b0) begin errors++; $display("FAIL reset_idle_vld: got %b expected 0", dco_cc_valid_o); end
    endtask

    // +8 then 0 with Kp=1.0, Ki=0.25: 8+2=10, then 0+2=2; 2-edge latency.
    task automatic test_basic;
        do_reset();
        step(1'b1, 8'sd8, 1'b0);
        checks++; if (dco_cc_valid_o !== 1'b0) begin errors++; $display("FAIL basic_early0: vld got %b expected 0", dco_cc_valid_o); end
        step(1'b1, 8'sd0, 1'b0);
        checks++; if (dco_cc_valid_o !== 1'b0) begin errors++; $display("FAIL basic_early1: vld got %b expected 0", dco_cc_valid_o); end
        step(1'b0, 8'sd0, 1'b0);
        checks++; if (dco_cc_o !== 9'sd10 || dco_cc_valid_o !== 1'b1 || sat_o !== 1'b0) begin errors++; $display("FAIL basic_out0: got cc=%0d vld=%b sat=%b expected cc=10 vld=1 sat=0", dco_cc_o, dco_cc_valid_o, sat_o); end
        step(1'b0, 8'sd0, 1'b0);
        checks++; if (dco_cc_o !== 9'sd2 || dco_cc_valid_o !== 1'b1) begin errors++; $display("FAIL basic_out1: got cc=%0d vld=%b expected cc=2 vld=1", dco_cc_o, dco_cc_valid_o); end
        step(1'b0, 8'sd0, 1'b0);
        checks++; if (dco_cc_o !== 9'sd2 || dco_cc_valid_o !== 1'b0) begin errors++; $display("FAIL basic_hold: got cc=%0d vld=%b expected cc=2 vld=0", dco_cc_o, dco_cc_valid_o); end
    endtask

    // +127 back-to-back: integrator grows 31.75/sample until the output clips
    // at 255; the integrator stays at 127.0 so error 0 then gives 127.
    task automatic test_sat_pos;
        int   exp_o[6] = '{159, 191, 222, 254, 255, 127};
        logic exp_s[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(i < 6, (i < 5) ? 8'sd127 : 8'sd0, 1'b0);
            if (i >= 2) begin
                checks++;
                if (dco_cc_o !== 9'(exp_o[i-2]) || sat_o !== exp_s[i-2] || dco_cc_valid_o !== 1'b1) begin
                    errors++;
                    $display("FAIL sat_pos[%0d]: got cc=%0d sat=%b vld=%b expected cc=%0d sat=%b vld=1", i-2, dco_cc_o, sat_o, dco_cc_valid_o, exp_o[i-2], exp_s[i-2]);
                end
            end
        end
        step(1'b0, 8'sd0, 1'b0);
        checks++; if (dco_cc_o !== 9'sd127 || dco_cc_valid_o !== 1'b0) begin errors++; $display("FAIL sat_pos_hold: got cc=%0d vld=%b expected cc=127 vld=0", dco_cc_o, dco_cc_valid_o); end
    endtask

    // -128 mirror: -256 is exactly representable (no clip), the next sample
    // clips and the integrator holds at -128.0, so error 0 gives -128.
    task automatic test_sat_neg;
        int   exp_o[6] = '{-160, -192, -224, -256, -256, -128};
        logic exp_s[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(i < 6, (i < 5) ? -8'sd128 : 8'sd0, 1'b0);
            if (i >= 2) begin
                checks++;
                if (dco_cc_o !== 9'(exp_o[i-2]) || sat_o !== exp_s[i-2] || dco_cc_valid_o !== 1'b1) begin
                    errors++;
                    $display("FAIL sat_neg[%0d]: got cc=%0d sat=%b vld=%b expected cc=%0d sat=%b vld=1", i-2, dco_cc_o, sat_o, dco_cc_valid_o, exp_o[i-2], exp_s[i-2]);
                end
            end
        end
    endtask

    // Frozen +8 gives P only (8); integrator stays 0, then 0 -> 0, +8 -> 10.
    task automatic test_freeze;
        int exp_o[5] = '{8, 8, 8, 0, 10};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            if (i < 3)       step(1'b1, 8'sd8, 1'b1);
            else if (i == 3) step(1'b1, 8'sd0, 1'b0);
            else if (i == 4) step(1'b1, 8'sd8, 1'b0);
            else             step(1'b0, 8'sd0, 1'b0);
            if (i >= 2) begin
                checks++;
                if (dco_cc_o !== 9'(exp_o[i-2]) || dco_cc_valid_o !== 1'b1) begin
                    errors++;
                    $display("FAIL freeze[%0d]: got cc=%0d vld=%b expected cc=%0d vld=1", i-2, dco_cc_o, dco_cc_valid_o, exp_o[i-2]);
                end
            end
        end
    endtask

    // 16 in-threshold samples lock (gear build); a +4 sample then uses the
    // tracking gains (Kp=0.5, Ki=1/16): 2.0+0.25 -> 2 instead of 4+1 -> 5.
    // Four samples of +20 unlock.
    task automatic test_lock;
        do_reset();
        for (int i = 0; i < 15; i++) step(1'b1, (i % 2 == 1) ? -8'sd1 : 8'sd1, 1'b0);
        step(1'b0, 8'sd0, 1'b0);
        step(1'b0, 8'sd0, 1'b0);
        checks++; if (locked_o !== 1'b0) begin errors++; $display("FAIL lock_after15: got %b expected 0", locked_o); end
        step(1'b1, -8'sd1, 1'b0);
        step(1'b0, 8'sd0, 1'b0);
        step(1'b0, 8'sd0, 1'b0);
        checks++; if (locked_o !== GEAR) begin errors++; $display("FAIL lock_after16: got %b expected %b", locked_o, GEAR); end
        step(1'b1, 8'sd4, 1'b0);
        step(1'b0, 8'sd0, 1'b0);
        step(1'b0, 8'sd0, 1'b0);
        checks++; if (dco_cc_o !== (GEAR ? 9'sd2 : 9'sd5)) begin errors++; $display("FAIL lock_gear_cc: got %0d expected %0d", dco_cc_o, GEAR ? 2 : 5); end
        for (int i = 0; i < 3; i++) step(1'b1, 8'sd20, 1'b0);
        step(1'b0, 8'sd0, 1'b0);
        step(1'b0, 8'sd0, 1'b0);
        checks++; if (locked_o !== GEAR) begin errors++; $display("FAIL unlock_after3: got %b expected %b", locked_o, GEAR); end
        step(1'b1, 8'sd20, 1'b0);
        step(1'b0, 8'sd0, 1'b0);
        step(1'b0, 8'sd0, 1'b0);
        checks++; if (locked_o !== 1'b0) begin errors++; $display("FAIL unlock_after4: got %b expected 0", locked_o); end
    endtask

    // Reset lands between a sample's capture and its strobe.
    task automatic test_reset_mid;
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 8'sd127, 1'b0);
        step(1'b1, 8'sd8, 1'b0);
        step(1'b0, 8'sd0, 1'b0);
        checks++; if (sat_o !== 1'b1 || dco_cc_o !== 9'sd255) begin errors++; $display("FAIL rstmid_pre: got cc=%0d sat=%b expected cc=255 sat=1", dco_cc_o, sat_o); end
        reset_i = 1'b1;
        #1;
        checks++; if (dco_cc_o !== 9'sd0 || sat_o !== 1'b0 || dco_cc_valid_o !== 1'b0 || locked_o !== 1'b0) begin errors++; $display("FAIL rstmid_async: got cc=%0d sat=%b vld=%b lock=%b expected all 0", dco_cc_o, sat_o, dco_cc_valid_o, locked_o); end
        @(negedge gen_clk_i);
        reset_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge gen_clk_i);
            checks++; if (dco_cc_valid_o !== 1'b0 || dco_cc_o !== 9'sd0) begin errors++; $display("FAIL rstmid_nostrobe[%0d]: got cc=%0d vld=%b expected cc=0 vld=0", i, dco_cc_o, dco_cc_valid_o); end
        end
        step(1'b1, 8'sd0, 1'b0);
        step(1'b0, 8'sd0, 1'b0);
        step(1'b0, 8'sd0, 1'b0);
        checks++; if (dco_cc_o !== 9'sd0 || dco_cc_valid_o !== 1'b1 || locked_o !== 1'b0) begin errors++; $display("FAIL rstmid_integ: got cc=%0d vld=%b lock=%b expected cc=0 vld=1 lock=0", dco_cc_o, dco_cc_valid_o, locked_o); end
    endtask

    initial begin
        kp_acq_i = 4'b0100;
        ki_acq_i = 6'b001000;
        kp_trk_i = 4'b0010;
        ki_trk_i = 6'b000010;
        test_reset();
        test_basic();
        test_sat_pos();
        test_sat_neg();
        test_freeze();
        test_lock();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
